mips_seq_ctrl: RTL and testbench

MIPS_SEQ_CTRL -- requirements
Module: mips_seq_ctrl

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mips_seq_decode.sv | 42 ++++
 rtl/mips_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mips_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller: opcodes, functs,
// FSM state codes, ALU operations and the instruction classes latched at decode.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_SLT = 2'b10
  } alu_op_e;

  // CLS_NONE doubles as the reset value and the "undecodable" result
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_BEQ   = 3'd4
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mips_seq_decode.sv
// Combinational opcode/funct classifier for mips_seq_ctrl.
// BEQ is recognised only when MIPS_SEQ_CTRL_BEQ_EN is defined.
module mips_seq_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic [1:0] alu_op
);

  always_comb begin
    cls    = CLS_NONE;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: cls = CLS_RTYPE;
          FN_SUB: begin
            cls    = CLS_RTYPE;
            alu_op = ALU_SUB;
          end
          FN_SLT: begin
            cls    = CLS_RTYPE;
            alu_op = ALU_SLT;
          end
          default: cls = CLS_NONE;
        endcase
      end
      OP_LW: cls = CLS_LW;
      OP_SW: cls = CLS_SW;
`ifdef MIPS_SEQ_CTRL_BEQ_EN
      OP_BEQ: begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
      end
`endif
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/exec/mem/wb with memory timeout trap.
// Optional BEQ support is enabled by defining MIPS_SEQ_CTRL_BEQ_EN.
module mips_seq_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      inst_in,
  input  logic             mem_ack,
  input  logic             alu_zero,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cls_q, cls_d;
  logic [5:0]        op_q, op_d;
  logic [5:0]        fn_q, fn_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              retire;
  logic [2:0]        dec_cls;
  logic [1:0]        dec_alu;

  mips_seq_decode u_decode (
    .opcode (op_q),
    .funct  (fn_q),
    .cls    (dec_cls),
    .alu_op (dec_alu)
  );

`ifndef MIPS_SEQ_CTRL_BEQ_EN
  logic unused_in;
  assign unused_in = alu_zero ^ (^inst_in[25:6]);
`else
  logic unused_in;
  assign unused_in = ^inst_in[25:6];
`endif

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    op_d       = op_q;
    fn_d       = fn_q;
    wait_d     = '0;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_we     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 1'b0;
    alu_op     = ALU_ADD;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      ST_IDLE: if (en) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          op_d    = inst_in[31:26];
          fn_d    = inst_in[5:0];
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        alu_op = dec_alu;
        cls_d  = dec_cls;
        if (dec_cls == CLS_NONE) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op = dec_alu;
        case (cls_q)
          CLS_RTYPE:     state_d = ST_WB;
          CLS_LW, CLS_SW: state_d = ST_MEM;
`ifdef MIPS_SEQ_CTRL_BEQ_EN
          CLS_BEQ: begin
            pc_wr  = alu_zero;
            pc_src = alu_zero;
            retire = 1'b1;
          end
`endif
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (cls_q == CLS_SW);
        if (mem_ack) begin
          if (cls_q == CLS_LW) state_d = ST_WB;
          else retire = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = (cls_q == CLS_RTYPE);
        mem_to_reg = (cls_q == CLS_LW);
        retire     = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase

    if (retire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = en ? ST_FETCH : ST_IDLE;
    end

    // Strobes are silenced while reset is held, even before the reset edge lands
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_sel    = 1'b0;
      mem_we     = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      pc_src     = 1'b0;
      alu_op     = ALU_ADD;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_NONE;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Self-checking bench for mips_seq_ctrl: a per-instruction cycle plan is built from the
// instruction-set rules, then replayed against the DUT one clock at a time.
module tb_mips_seq_ctrl;

  localparam int TMO = 15;
  localparam int C_ILL = 0, C_R = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, mem_ack, alu_zero;
  logic [31:0] inst_in;
  logic        mem_req, mem_sel, mem_we, ir_wr, pc_wr, pc_src;
  logic [1:0]  alu_op;
  logic        reg_wr, reg_dst, mem_to_reg, busy, illegal, timeout;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic [10:0] obs_outs;

  mips_seq_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inst_in(inst_in), .mem_ack(mem_ack),
    .alu_zero(alu_zero), .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .alu_op(alu_op), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .busy(busy), .illegal(illegal),
    .timeout(timeout), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs_outs = {mem_req, mem_sel, mem_we, ir_wr, pc_wr, pc_src, alu_op,
                     reg_wr, reg_dst, mem_to_reg};

  typedef struct {
    logic [2:0]  st;
    logic        en;
    logic        ack;
    logic        zero;
    logic [10:0] outs;
    logic        ill;
    logic        tmo;
    int          cnt;
  } cyc_t;

  cyc_t plan[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cnt;
  logic m_ill, m_tmo, b_en, b_zero, idle_now;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] ov(input logic req, sel, we, ir, pcw, pcs,
                                     input logic [1:0] aop, input logic rw, rd, m2r);
    return {req, sel, we, ir, pcw, pcs, aop, rw, rd, m2r};
  endfunction

  function automatic void classify(input logic [31:0] inst, output int cls,
                                   output logic [1:0] aop);
    int op, fn;
    op  = int'(inst >> 26);
    fn  = int'(inst & 32'h3f);
    cls = C_ILL;
    aop = 2'd0;
    if (op == 0 && fn == 32) cls = C_R;
    else if (op == 0 && fn == 34) begin cls = C_R; aop = 2'd1; end
    else if (op == 0 && fn == 42) begin cls = C_R; aop = 2'd2; end
    else if (op == 35) cls = C_LW;
    else if (op == 43) cls = C_SW;
`ifdef MIPS_SEQ_CTRL_BEQ_EN
    else if (op == 4) begin cls = C_BEQ; aop = 2'd1; end
`endif
  endfunction

  function automatic void add_cyc(input logic [2:0] st, input logic ack,
                                  input logic [10:0] outs);
    cyc_t c;
    c.st = st; c.en = b_en; c.ack = ack; c.zero = b_zero; c.outs = outs;
    c.ill = m_ill; c.tmo = m_tmo; c.cnt = m_cnt;
    plan.push_back(c);
  endfunction

  function automatic void retire();
    m_cnt = (m_cnt + 1) % 65536;
    if (!b_en) begin
      add_cyc(3'd0, noise(), 11'd0);
      idle_now = 1'b1;
    end
  endfunction

  function automatic void trap_tail();
    repeat (3) add_cyc(3'd6, noise(), 11'd0);
  endfunction

  function automatic void begin_instr();
    b_en = 1'b1;
    if (idle_now) begin
      add_cyc(3'd0, noise(), 11'd0);
      idle_now = 1'b0;
    end
  endfunction

  // fw/mw: cycles without ack before the ack; >= TMO means never acked
  function automatic void build_instr(input logic [31:0] inst, input int fw, input int mw,
                                      input bit drop_en, input int zmode);
    int cls;
    logic [1:0] aop;
    logic hit;
    classify(inst, cls, aop);
    for (int i = 0; i <= fw && i < TMO; i++)
      add_cyc(3'd1, i == fw, ov(1, 0, 0, i == fw, i == fw, 0, 2'd0, 0, 0, 0));
    if (fw >= TMO) begin m_tmo = 1'b1; trap_tail(); return; end
    add_cyc(3'd2, noise(), ov(0, 0, 0, 0, 0, 0, aop, 0, 0, 0));
    if (cls == C_ILL) begin m_ill = 1'b1; trap_tail(); return; end
    if (drop_en) b_en = 1'b0;
    b_zero = (zmode < 0) ? noise() : 1'(zmode);
    hit = (cls == C_BEQ) && b_zero;
    add_cyc(3'd3, noise(), ov(0, 0, 0, 0, hit, hit, aop, 0, 0, 0));
    if (cls == C_BEQ) begin retire(); return; end
    if (cls == C_LW || cls == C_SW) begin
      for (int i = 0; i <= mw && i < TMO; i++)
        add_cyc(3'd4, i == mw, ov(1, 1, cls == C_SW, 0, 0, 0, 2'd0, 0, 0, 0));
      if (mw >= TMO) begin m_tmo = 1'b1; trap_tail(); return; end
      if (cls == C_SW) begin retire(); return; end
    end
    add_cyc(3'd5, noise(), ov(0, 0, 0, 0, 0, 0, 2'd0, 1, cls == C_R, cls == C_LW));
    retire();
  endfunction

  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge clk);
      en = c.en; mem_ack = c.ack; alu_zero = c.zero;
      #1;
      chk("state", 32'(state), 32'(c.st));
      chk("strobes", 32'(obs_outs), 32'(c.outs));
      chk("busy", 32'(busy), 32'(c.st != 3'd0));
      chk("illegal", 32'(illegal), 32'(c.ill));
      chk("timeout", 32'(timeout), 32'(c.tmo));
      chk("instr_count", 32'(instr_count), 32'(c.cnt));
    end
  endtask

  task automatic run_instr(input logic [31:0] inst, input int fw, input int mw,
                           input bit drop_en, input int zmode);
    begin_instr();
    build_instr(inst, fw, mw, drop_en, zmode);
    inst_in = inst;
    run_plan();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = noise(); mem_ack = noise();
    #1;
    chk("rst_strobes_before_edge", 32'(obs_outs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; mem_ack = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'(obs_outs), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    m_cnt = 0; m_ill = 1'b0; m_tmo = 1'b0; b_en = 1'b0; idle_now = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    int unsigned rs, rt, rd, pick;
    rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
`ifdef MIPS_SEQ_CTRL_BEQ_EN
    pick = $urandom_range(0, 5);
`else
    pick = $urandom_range(0, 4);
`endif
    case (pick)
      0: return (rs << 21) | (rt << 16) | (rd << 11) | 32;
      1: return (rs << 21) | (rt << 16) | (rd << 11) | 34;
      2: return (rs << 21) | (rt << 16) | (rd << 11) | 42;
      3: return (35 << 26) | (rs << 21) | (rt << 16) | $urandom_range(0, 65535);
      4: return (43 << 26) | (rs << 21) | (rt << 16) | $urandom_range(0, 65535);
      default: return (4 << 26) | (rs << 21) | (rt << 16) | $urandom_range(0, 65535);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0; inst_in = 32'd0;
    m_cnt = 0; m_ill = 1'b0; m_tmo = 1'b0; b_en = 1'b0; b_zero = 1'b0; idle_now = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("init_state", 32'(state), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_strobes", 32'(obs_outs), 32'd0);
    chk("init_count", 32'(instr_count), 32'd0);
    chk("init_flags", 32'({illegal, timeout}), 32'd0);
    rst_n = 1'b1;

    run_instr(32'h00221820, 2, 0, 1'b0, -1);
    run_instr(32'h8C220004, 0, 0, 1'b0, -1);
    run_instr(32'hAC220004, 0, 0, 1'b0, -1);

    for (int i = 0; i < 24; i++)
      run_instr(rand_inst(), (i == 5) ? TMO - 1 : $urandom_range(0, 4),
                (i % 7 == 3) ? TMO - 1 : $urandom_range(0, 4), 1'b0, -1);

    run_instr(32'h00221822, TMO - 1, 0, 1'b0, -1);
    run_instr(32'h00221820, 1, 0, 1'b1, -1);
    chk("idle_after_drop_en", 32'(state), 32'd0);

`ifdef MIPS_SEQ_CTRL_BEQ_EN
    run_instr(32'h10220003, 0, 0, 1'b0, 1);
    run_instr(32'h10220003, 1, 0, 1'b0, 0);
`else
    run_instr(32'h10220003, 0, 0, 1'b0, -1);
    do_reset();
`endif

    run_instr(32'h00221820, 0, 0, 1'b0, -1);
    run_instr(32'hFC000000, 1, 0, 1'b0, -1);
    do_reset();

    run_instr(32'h00221820, TMO, 0, 1'b0, -1);
    do_reset();
    run_instr(32'h8C220004, 0, TMO, 1'b0, -1);
    do_reset();

    begin_instr();
    repeat (3) add_cyc(3'd1, 1'b0, ov(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
    run_plan();
    do_reset();
    b_en = 1'b0;
    add_cyc(3'd0, 1'b1, 11'd0);
    add_cyc(3'd0, 1'b1, 11'd0);
    run_plan();
    run_instr(32'h0022182A, 0, 0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
